// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: shares the single register-file write port between LSU, MDU and ALU.
// Define RF_WB_ARB_RR_EN for round-robin arbitration; otherwise fixed priority LSU > MDU > ALU.
module rf_wb_arbiter #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lsu_vld,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_d,
  input  logic            mdu_vld,
  input  logic [4:0]      mdu_rd,
  input  logic [XLEN-1:0] mdu_d,
  input  logic            alu_vld,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_d,
  output logic            lsu_rdy,
  output logic            mdu_rdy,
  output logic            alu_rdy,
  output logic            wr,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] d,
  output logic            byp_vld,
  output logic [4:0]      byp_rd,
  output logic [XLEN-1:0] byp_d
);

  typedef enum logic [1:0] {
    REQ_LSU = 2'd0,
    REQ_MDU = 2'd1,
    REQ_ALU = 2'd2
  } req_e;

  logic [2:0]      nz_req;
  logic [2:0]      disc;
  logic [2:0]      gnt;
  logic            any_gnt;
  req_e            win;
  logic [4:0]      win_rd;
  logic [XLEN-1:0] win_d;

  logic            wr_q, wr_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] d_q,  d_d;

  // x0 writes are discarded: they handshake at once and never compete for the port
  assign nz_req  = {alu_vld && (alu_rd != '0), mdu_vld && (mdu_rd != '0), lsu_vld && (lsu_rd != '0)};
  assign disc    = {alu_vld && (alu_rd == '0), mdu_vld && (mdu_rd == '0), lsu_vld && (lsu_rd == '0)};
  assign any_gnt = |nz_req;

`ifdef RF_WB_ARB_RR_EN
  req_e last_q, last_d;
  req_e cand0, cand1, cand2;

  function automatic req_e succ(input req_e r);
    case (r)
      REQ_LSU: return REQ_MDU;
      REQ_MDU: return REQ_ALU;
      default: return REQ_LSU;
    endcase
  endfunction

  always_comb begin
    cand0 = succ(last_q);
    cand1 = succ(cand0);
    cand2 = succ(cand1);
  end

  always_comb begin
    win = cand2;
    if (nz_req[cand0])      win = cand0;
    else if (nz_req[cand1]) win = cand1;
  end

  always_comb begin
    last_d = last_q;
    if (any_gnt) last_d = win;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= REQ_ALU;
    else        last_q <= last_d;
  end
`else
  always_comb begin
    win = REQ_ALU;
    if (nz_req[REQ_LSU])      win = REQ_LSU;
    else if (nz_req[REQ_MDU]) win = REQ_MDU;
  end
`endif

  always_comb begin
    gnt = '0;
    if (any_gnt) gnt[win] = 1'b1;
  end

  assign lsu_rdy = disc[REQ_LSU] | gnt[REQ_LSU];
  assign mdu_rdy = disc[REQ_MDU] | gnt[REQ_MDU];
  assign alu_rdy = disc[REQ_ALU] | gnt[REQ_ALU];

  always_comb begin
    case (win)
      REQ_LSU: begin win_rd = lsu_rd; win_d = lsu_d; end
      REQ_MDU: begin win_rd = mdu_rd; win_d = mdu_d; end
      default: begin win_rd = alu_rd; win_d = alu_d; end
    endcase
  end

  // Address/data hold when idle so the bypass keeps presenting the last write
  always_comb begin
    wr_d = any_gnt;
    rd_d = rd_q;
    d_d  = d_q;
    if (any_gnt) begin
      rd_d = win_rd;
      d_d  = win_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= 1'b0;
      rd_q <= '0;
      d_q  <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      d_q  <= d_d;
    end
  end

  assign wr      = wr_q;
  assign rd      = rd_q;
  assign d       = d_q;
  assign byp_vld = wr_q;
  assign byp_rd  = rd_q;
  assign byp_d   = d_q;

endmodule
